// File: rtl/alu_pipe.sv
// alu_pipe: pipelined 74181-style ALU with a stored carry for multi-word chains.
// Define ALU_PIPE_IN_REG_EN to register operands ahead of the compute stage.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             mode_i,
  input  logic [3:0]       select_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             carry_i,
  input  logic             chain_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             eq_o
);

  logic             c_valid;
  logic             c_mode;
  logic [3:0]       c_sel;
  logic [WIDTH-1:0] c_a;
  logic [WIDTH-1:0] c_b;
  logic             c_carry;
  logic             c_chain;

  logic             out_ready;
  logic             load;
  logic             stored_carry;

  assign out_ready = !valid_o || ready_i;
  assign load      = c_valid && out_ready;

`ifdef ALU_PIPE_IN_REG_EN
  logic             in_valid;
  logic             in_mode;
  logic [3:0]       in_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             in_chain;

  assign ready_o = !in_valid || out_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_valid <= 1'b0;
      in_mode  <= 1'b0;
      in_sel   <= '0;
      in_a     <= '0;
      in_b     <= '0;
      in_carry <= 1'b0;
      in_chain <= 1'b0;
    end else if (ready_o) begin
      in_valid <= valid_i;
      if (valid_i) begin
        in_mode  <= mode_i;
        in_sel   <= select_i;
        in_a     <= operand_a_i;
        in_b     <= operand_b_i;
        in_carry <= carry_i;
        in_chain <= chain_i;
      end
    end
  end

  assign c_valid = in_valid;
  assign c_mode  = in_mode;
  assign c_sel   = in_sel;
  assign c_a     = in_a;
  assign c_b     = in_b;
  assign c_carry = in_carry;
  assign c_chain = in_chain;
`else
  assign ready_o = out_ready;
  assign c_valid = valid_i;
  assign c_mode  = mode_i;
  assign c_sel   = select_i;
  assign c_a     = operand_a_i;
  assign c_b     = operand_b_i;
  assign c_carry = carry_i;
  assign c_chain = chain_i;
`endif

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic [WIDTH-1:0] f;
  logic             co;
  logic             ov;

  always_comb begin
    x   = c_a
        | ({WIDTH{c_sel[0]}} & c_b)
        | ({WIDTH{c_sel[1]}} & ~c_b);
    y   = (c_a & c_b & {WIDTH{c_sel[3]}})
        | (c_a & ~c_b & {WIDTH{c_sel[2]}});
    cin = c_chain ? stored_carry : c_carry;
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    f   = sum[WIDTH-1:0];
    co  = sum[WIDTH];
    ov  = (x[WIDTH-1] == y[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
    if (c_mode) begin
      f  = ~(x ^ y);
      co = 1'b0;
      ov = 1'b0;
    end
  end

  // Stored carry is updated only as an arithmetic op lands, so op n+1 sees it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_o      <= 1'b0;
      result_o     <= '0;
      carry_o      <= 1'b0;
      overflow_o   <= 1'b0;
      zero_o       <= 1'b0;
      eq_o         <= 1'b0;
      stored_carry <= 1'b0;
    end else if (load) begin
      valid_o    <= 1'b1;
      result_o   <= f;
      carry_o    <= co;
      overflow_o <= ov;
      zero_o     <= (f == '0);
      eq_o       <= &f;
      if (!c_mode) stored_carry <= co;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized scoreboard bench for alu_pipe against an
// in-order behavioural model of the 32-function ALU with carry chaining.
module tb_alu_pipe;

`ifdef ALU_PIPE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
    bit          lat;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        mode_i = 1'b0;
  logic [3:0]  select_i = '0;
  logic [15:0] operand_a_i = '0;
  logic [15:0] operand_b_i = '0;
  logic        carry_i = 1'b0;
  logic        chain_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] result_o;
  logic        carry_o;
  logic        overflow_o;
  logic        zero_o;
  logic        eq_o;

  alu_pipe #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .select_i(select_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .carry_i(carry_i), .chain_i(chain_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .carry_o(carry_o),
    .overflow_o(overflow_o), .zero_o(zero_o), .eq_o(eq_o)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rmode = 0;
  bit   mc = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: ready_i = 1'($urandom_range(0, 1));
      2: ready_i = 1'b0;
      default: ready_i = 1'b1;
    endcase
  end

  // Reference: the ALU as an in-order machine; arithmetic is plain integer add.
  function automatic exp_t model(bit m, logic [3:0] s,
                                 logic [15:0] a, logic [15:0] b, bit cin);
    exp_t e;
    logic [15:0] x, y, f;
    int unsigned t;
    x = a | (s[0] ? b : 16'h0) | (s[1] ? ~b : 16'h0);
    y = (s[3] ? (a & b) : 16'h0) | (s[2] ? (a & ~b) : 16'h0);
    if (m) begin
      f = ~(x ^ y);
      e.c = 1'b0;
      e.v = 1'b0;
    end else begin
      t = int'(x) + int'(y) + int'(cin);
      f = t[15:0];
      e.c = t[16];
      e.v = (x[15] == y[15]) && (f[15] != x[15]);
    end
    e.r = f;
    e.z = (f == 16'h0);
    e.e = (f == 16'hFFFF);
    e.lat = 1'b0;
    e.t = 0;
    return e;
  endfunction

  task automatic issue(input bit m, input logic [3:0] s,
                       input logic [15:0] a, input logic [15:0] b,
                       input bit c, input bit ch,
                       input bit use_k, input logic [15:0] k);
    exp_t e;
    int n = 0;
    mode_i = m;
    select_i = s;
    operand_a_i = a;
    operand_b_i = b;
    carry_i = c;
    chain_i = ch;
    valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout: ready_o stuck at 0, want 1");
        miscompares++;
        valid_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    e = model(m, s, a, b, (!m && ch) ? mc : (!m && c));
    if (!m) mc = e.c;
    if (use_k) e.r = k;
    e.lat = (q.size() == 0) && (rmode == 0);
    e.t = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    rmode = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: %0d results outstanding, want 0", q.size());
      miscompares++;
      q.delete();
    end
    #1;
  endtask

  bit          prev_stall = 1'b0;
  bit          head_seen = 1'b0;
  logic [19:0] held;

  always @(negedge clk) begin
    if (!rst_n_i) begin
      prev_stall = 1'b0;
      head_seen = 1'b0;
    end else begin
      if (prev_stall && valid_o) begin
        vectors++;
        if ({result_o, carry_o, overflow_o, zero_o, eq_o} != held) begin
          $display("FAIL stall_hold: got %h, want %h",
                   {result_o, carry_o, overflow_o, zero_o, eq_o}, held);
          miscompares++;
        end
      end
      if (valid_o && !head_seen) begin
        head_seen = 1'b1;
        if (q.size() != 0 && q[0].lat) begin
          vectors++;
          if (cyc - q[0].t != LAT) begin
            $display("FAIL latency: got %0d cycles, want %0d",
                     cyc - q[0].t, LAT);
            miscompares++;
          end
        end
      end
      if (valid_o && ready_i) begin
        vectors++;
        if (q.size() == 0) begin
          $display("FAIL spurious: result %h with no op outstanding", result_o);
          miscompares++;
        end else begin
          exp_t e;
          e = q.pop_front();
          if (result_o !== e.r || carry_o !== e.c || overflow_o !== e.v ||
              zero_o !== e.z || eq_o !== e.e) begin
            $display("FAIL result: got r=%h c=%b v=%b z=%b e=%b, want r=%h c=%b v=%b z=%b e=%b",
                     result_o, carry_o, overflow_o, zero_o, eq_o,
                     e.r, e.c, e.v, e.z, e.e);
            miscompares++;
          end
        end
        head_seen = 1'b0;
      end
      prev_stall = valid_o && !ready_i;
      held = {result_o, carry_o, overflow_o, zero_o, eq_o};
    end
  end

  initial begin
    idle(3);
    rst_n_i = 1'b1;
    @(negedge clk);
    vectors++;
    if ({valid_o, result_o, carry_o, overflow_o, zero_o, eq_o} !== 21'h0) begin
      $display("FAIL reset_state: got v=%b r=%h flags=%b%b%b%b, want all 0",
               valid_o, result_o, carry_o, overflow_o, zero_o, eq_o);
      miscompares++;
    end
    @(posedge clk);
    #1;

    issue(0, 4'b1001, 16'h1234, 16'h0FFF, 0, 0, 1, 16'h2233);
    drain();
    issue(0, 4'b1001, 16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000);
    drain();
    issue(0, 4'b1001, 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000);
    issue(0, 4'b1001, 16'h0000, 16'h0000, 0, 1, 1, 16'h0001);
    drain();
    issue(0, 4'b0110, 16'h5A5A, 16'h5A5A, 0, 0, 1, 16'hFFFF);
    drain();

    // Set stored carry, sweep logic ops, then show the carry survived.
    issue(0, 4'b1001, 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000);
    for (int s = 0; s < 16; s++) begin
      issue(1, 4'(s), 16'hF0F0, 16'hCCCC, 1'($urandom_range(0, 1)), 1,
            (s == 9) || (s == 3), (s == 9) ? 16'hC3C3 : 16'h0000);
    end
    issue(0, 4'b1001, 16'h0000, 16'h0000, 0, 1, 1, 16'h0001);
    drain();

    rmode = 1;
    for (int i = 0; i < 8; i++) begin
      issue(0, 4'b1001, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 0, 16'h0);
    end
    drain();

    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 16'h0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    // Reset with two ops in flight while downstream is stalled.
    rmode = 2;
    idle(2);
    mode_i = 1'b0;
    select_i = 4'b1001;
    operand_a_i = 16'hFFFF;
    operand_b_i = 16'h0001;
    carry_i = 1'b0;
    chain_i = 1'b0;
    valid_i = 1'b1;
    idle(1);
    operand_a_i = 16'h8000;
    operand_b_i = 16'h8000;
    idle(1);
    valid_i = 1'b0;
    rst_n_i = 1'b0;
    idle(1);
    rst_n_i = 1'b1;
    mc = 1'b0;
    rmode = 0;
    @(negedge clk);
    vectors++;
    if (valid_o !== 1'b0) begin
      $display("FAIL reset_flush: valid_o=%b, want 0", valid_o);
      miscompares++;
    end
    @(posedge clk);
    #1;
    issue(0, 4'b1001, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000);
    drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 4-bit 74181-style ALU slice. It implements the same 32-function set (16 logic, 16 arithmetic) over a WIDTH-bit datapath, with registered results and flags behind a valid/ready handshake. A stored carry allows multi-word arithmetic to be chained across consecutive operations. It sits between the operand-fetch stage and the writeback stage of the datapath.

## Interface
- WIDTH, 16: datapath width; multiple of 4, minimum 4.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  synchronous, active-low reset.
- valid_i  input  1  operation presented on the *_i operand and control inputs.
- ready_o  output  1  block accepts the operation this cycle.
- mode_i  input  1  1 = logic mode, 0 = arithmetic mode.
- select_i  input  4  function select S[3:0].
- operand_a_i  input  WIDTH  operand A.
- operand_b_i  input  WIDTH  operand B.
- carry_i  input  1  active-high carry-in, used when chain_i = 0.
- chain_i  input  1  1 = use the stored carry as carry-in.
- valid_o  output  1  result and flags valid.
- ready_i  input  1  downstream accepts the result.
- result_o  output  WIDTH  function output F.
- carry_o  output  1  carry out of bit WIDTH-1; 0 in logic mode.
- overflow_o  output  1  signed overflow; 0 in logic mode.
- zero_o  output  1  F == 0.
- eq_o  output  1  F is all ones (A == B compare under S = 0110, carry-in 0).

## Operation
- Per-bit terms:
  - X = A | (S0 & B) | (S1 & ~B)
  - Y = (A & B & S3) | (A & ~B & S2)
- Logic mode: F = ~(X ^ Y). Examples: S = 1001 → XNOR, S = 0011 → 0, S = 1111 → A, S = 0000 → ~A.
- Arithmetic mode: {c, F} = X + Y + cin, computed at WIDTH+1 bits. Examples:
  - S = 1001 → A + B + cin.
  - S = 0110 → A − B − 1 + cin.
  - S = 1111 → A − 1 + cin.
  - S = 0000 → A + cin.
- cin = chain_i ? stored carry : carry_i. In logic mode, chain_i and carry_i are ignored.
- overflow_o = (X[MSB] == Y[MSB]) && (F[MSB] != X[MSB]).
- Stored carry:
  - Reset value 0.
  - Loaded with carry_o when an arithmetic result enters the output register.
  - Unchanged by logic operations.
- Chained operations use the carry of the immediately preceding arithmetic operation in issue order, including while that operation is still held in the output register.
- Handshake: a transfer occurs when valid and ready are both 1. Operations complete strictly in order; none are dropped or duplicated.

## Timing
- Reset: valid_o = 0, result_o = 0, all flags = 0, stored carry = 0, input stage empty. Reset mid-operation discards all in-flight operations.
- Latency with ALU_PIPE_IN_REG_EN undefined: 1 cycle, from accept to valid_o.
- Latency with ALU_PIPE_IN_REG_EN defined: 2 cycles, from accept to valid_o.
- Each stage is ready when it is empty or its contents move forward this cycle. ready_o may depend combinationally on ready_i.
- Throughput: 1 operation per cycle when ready_i is held at 1.
- Stall (valid_o = 1, ready_i = 0): result_o and all flags hold stable; the stored carry does not change.
- Simultaneous accept and drain: allowed, with no bubble inserted.
- Compute stage:
  - Reads the stored carry in the same cycle its result loads the output register.
  - The stored carry written by op n is therefore visible to op n+1 with no stall, at any latency.

## Configuration
- ALU_PIPE_IN_REG_EN:
  - Defined: an input register stage is inserted before the compute stage. Latency 2; operands are registered before the WIDTH-bit carry chain for timing closure.
  - Undefined: operands feed the compute logic directly. Latency 1.
- Function, flags and chaining are identical in both builds.

## Test plan
- WIDTH = 16, S = 1001, arith, carry_i = 0:
  - A = 0x1234, B = 0x0FFF → result_o = 0x2233, carry_o = 0, overflow_o = 0.
  - A = 0x7FFF, B = 0x0001 → result_o = 0x8000, overflow_o = 1.
- Chained 32-bit add, both ops with S = 1001, arith, back-to-back:
  - Op 1: A = 0xFFFF, B = 0x0001, carry_i = 0 → result_o = 0x0000, carry_o = 1, zero_o = 1.
  - Op 2: A = 0x0000, B = 0x0000, chain_i = 1 → result_o = 0x0001.
  - Latency must match the build: 1 cycle without, 2 cycles with ALU_PIPE_IN_REG_EN.
- Compare, S = 0110, arith, carry_i = 0, A = B = 0x5A5A → result_o = 0xFFFF, eq_o = 1, carry_o = 0.
- Logic sweep, mode_i = 1, all 16 select values, A = 0xF0F0, B = 0xCCCC:
  - Results match ~(X ^ Y), e.g. S = 1001 → 0xC3C3, S = 0011 → 0x0000.
  - carry_o = 0 and overflow_o = 0 throughout.
  - Stored carry unchanged.
- Backpressure: 8 operations issued with ready_i toggling randomly → outputs held stable while stalled; all 8 results in order, none lost or duplicated.
- Reset mid-stream: rst_n_i = 0 for 1 cycle with 2 operations in flight → next cycle valid_o = 0; stored carry = 0, so a following chained add of 0 + 0 → result_o = 0.
